// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - captures a selected pixel row after a settle interval and streams it out pixel by pixel
module pixel_readout #(
  parameter int PIXEL_ARRAY_WIDTH  = 4,
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int PIXEL_BITS         = 8,
  parameter int SETTLE_CYCLES      = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [PIXEL_ARRAY_HEIGHT-1:0]             p_row_select,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   p_data,
  output logic [PIXEL_BITS-1:0]                     out_data,
  output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]     out_row,
  output logic [$clog2(PIXEL_ARRAY_WIDTH)-1:0]      out_col,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      frame_done,
  output logic                                      overrun,
  output logic                                      sel_error
);

  localparam int ROW_W = $clog2(PIXEL_ARRAY_HEIGHT);
  localparam int COL_W = $clog2(PIXEL_ARRAY_WIDTH);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PIXEL_ARRAY_HEIGHT-1:0] SEL_ONE  = PIXEL_ARRAY_HEIGHT'(1);
  localparam logic [COL_W-1:0]              LAST_COL = COL_W'(PIXEL_ARRAY_WIDTH - 1);
  localparam logic [ROW_W-1:0]              LAST_ROW = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [CNT_W-1:0]              CAP_CNT  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DRAIN} state_t;

  state_t                                  state_q;
  logic [PIXEL_ARRAY_HEIGHT-1:0]           last_q;
  logic [PIXEL_ARRAY_HEIGHT-1:0]           cand_q;
  logic [CNT_W-1:0]                        cnt_q;
  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] buf_q;
  logic [PIXEL_BITS-1:0]                   data_q;
  logic [ROW_W-1:0]                        row_q;
  logic [COL_W-1:0]                        col_q;
  logic                                    valid_q;
  logic                                    frame_q;
  logic                                    overrun_q;
  logic                                    sel_err_q;

  logic                                    multi_d;
  logic                                    onehot_d;
  logic [PIXEL_ARRAY_HEIGHT-1:0]           eff_sel_d;
  logic [ROW_W-1:0]                        row_enc_d;
  logic [COL_W-1:0]                        next_col_d;
  logic [PIXEL_BITS-1:0]                   next_pix_d;

  assign out_data   = data_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_valid  = valid_q;
  assign frame_done = frame_q;
  assign overrun    = overrun_q;
  assign sel_error  = sel_err_q;

  // Classify the select (multi-hot is treated as idle), encode the row and pick the next buffered pixel
  always_comb begin
    multi_d    = |(p_row_select & (p_row_select - SEL_ONE));
    eff_sel_d  = multi_d ? '0 : p_row_select;
    onehot_d   = |eff_sel_d;
    row_enc_d  = '0;
    for (int r = 0; r < PIXEL_ARRAY_HEIGHT; r++) begin
      if (eff_sel_d[r]) row_enc_d = ROW_W'(r);
    end
    next_col_d = col_q + COL_W'(1);
    next_pix_d = '0;
    for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
      if (next_col_d == COL_W'(c)) next_pix_d = buf_q[c*PIXEL_BITS +: PIXEL_BITS];
    end
  end

  // Readout FSM: detect a new row, wait for it to settle, capture it, then drain it over the handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (multi_d) sel_err_q <= 1'b1;
      // Deselecting re-arms capture of the same row
      if (eff_sel_d == '0) last_q <= '0;
      case (state_q)
        IDLE: begin
          if (onehot_d && eff_sel_d != last_q) begin
            state_q <= SETTLE;
            cand_q  <= eff_sel_d;
            cnt_q   <= CNT_W'(1);
          end
        end
        SETTLE: begin
          if (eff_sel_d == cand_q) begin
            if (cnt_q >= CAP_CNT) begin
              buf_q   <= p_data;
              data_q  <= p_data[PIXEL_BITS-1:0];
              row_q   <= row_enc_d;
              col_q   <= '0;
              last_q  <= cand_q;
              valid_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          // A new row while busy is dropped for good and flagged
          if (onehot_d && eff_sel_d != last_q) begin
            overrun_q <= 1'b1;
            last_q    <= eff_sel_d;
          end
          if (valid_q && out_ready) begin
            if (col_q == LAST_COL) begin
              valid_q <= 1'b0;
              col_q   <= '0;
              state_q <= IDLE;
              if (row_q == LAST_ROW) frame_q <= 1'b1;
            end else begin
              col_q  <= next_col_d;
              data_q <= next_pix_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout.sv
// tb/tb_pixel_readout.sv - directed self-checking bench for pixel_readout
module tb_pixel_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  p_row_select;
  logic [31:0] p_data;
  logic [7:0]  out_data;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic        overrun;
  logic        sel_error;

  int n_checks = 0;
  int n_errors = 0;

  pixel_readout #(
    .PIXEL_ARRAY_WIDTH (4),
    .PIXEL_ARRAY_HEIGHT(4),
    .PIXEL_BITS        (8),
    .SETTLE_CYCLES     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .p_row_select(p_row_select),
    .p_data      (p_data),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .sel_error   (sel_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  // Expects the row already valid and out_ready high: four back-to-back transfers
  task automatic drain_expect(input string tag, input logic [31:0] word, input logic [1:0] row);
    for (int c = 0; c < 4; c++) begin
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, out_data}, {24'd0, word[c*8 +: 8]});
      check({tag, "_col"}, {30'd0, out_col}, c);
      check({tag, "_row"}, {30'd0, out_row}, {30'd0, row});
      tick();
    end
  endtask

  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] word;

  initial begin
    reset        = 1'b1;
    p_row_select = 4'b0000;
    p_data       = 32'h0;
    out_ready    = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_flags", {29'd0, frame_done, overrun, sel_error}, 32'd0);
    #4 reset = 1'b0;
    tick();

    // Single row with exact latency
    p_row_select = 4'b0001;
    p_data       = 32'h44332211;
    tick();
    check("t1_settle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    drain_expect("t1", 32'h44332211, 2'd0);
    check("t1_done_valid", {31'd0, out_valid}, 32'd0);
    check("t1_frame", {31'd0, frame_done}, 32'd0);
    p_row_select = 4'b0000;
    tick();

    // Full frame in row-major order
    for (int r = 0; r < 4; r++) begin
      p_row_select = 4'b0001 << r;
      word         = {4'(r), 4'd3, 4'(r), 4'd2, 4'(r), 4'd1, 4'(r), 4'd0};
      p_data       = word;
      wait_valid("t2_wait");
      drain_expect("t2", word, 2'(r));
      check("t2_after_valid", {31'd0, out_valid}, 32'd0);
      check("t2_frame", {31'd0, frame_done}, (r == 3) ? 32'd1 : 32'd0);
      p_row_select = 4'b0000;
      tick();
      check("t2_frame_pulse", {31'd0, frame_done}, 32'd0);
    end
    check("t2_overrun", {31'd0, overrun}, 32'd0);

    // Backpressure with ready pattern 1,0,0,1
    out_ready    = 1'b0;
    word         = 32'hDDCCBBAA;
    p_row_select = 4'b0100;
    p_data       = word;
    wait_valid("t3_wait");
    begin
      int e = 0;
      int k = 0;
      while (e < 4 && k < 24) begin
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        check("t3_data", {24'd0, out_data}, {24'd0, word[e*8 +: 8]});
        check("t3_col", {30'd0, out_col}, e);
        out_ready = pat[k % 4];
        tick();
        if (out_ready) e++;
        k++;
      end
      check("t3_count", e, 4);
    end
    check("t3_after_valid", {31'd0, out_valid}, 32'd0);
    out_ready    = 1'b1;
    p_row_select = 4'b0000;
    tick();

    // Glitch and multi-hot select
    p_row_select = 4'b0010;
    p_data       = 32'h99999999;
    tick();
    p_row_select = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_glitch_valid", {31'd0, out_valid}, 32'd0);
    end
    check("t4_glitch_flags", {30'd0, overrun, sel_error}, 32'd0);
    p_row_select = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_multi_valid", {31'd0, out_valid}, 32'd0);
    end
    check("t4_sel_error", {31'd0, sel_error}, 32'd1);
    p_row_select = 4'b0000;
    tick();

    // Overrun while stalled
    out_ready    = 1'b0;
    p_row_select = 4'b0001;
    p_data       = 32'h04030201;
    wait_valid("t5_wait");
    p_row_select = 4'b0010;
    p_data       = 32'hBBBBBBBB;
    tick();
    check("t5_overrun", {31'd0, overrun}, 32'd1);
    tick();
    tick();
    check("t5_hold_data", {24'd0, out_data}, 32'h01);
    check("t5_hold_col", {30'd0, out_col}, 32'd0);
    out_ready = 1'b1;
    drain_expect("t5", 32'h04030201, 2'd0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_row1", {31'd0, out_valid}, 32'd0);
      tick();
    end
    p_row_select = 4'b0000;
    tick();

    // Asynchronous reset mid-drain, then recapture of the held row
    out_ready    = 1'b0;
    p_row_select = 4'b0100;
    p_data       = 32'h0D0C0B0A;
    wait_valid("t6_wait");
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_data", {24'd0, out_data}, 32'd0);
    check("t6_rst_rowcol", {28'd0, out_row, out_col}, 32'd0);
    check("t6_rst_flags", {29'd0, frame_done, overrun, sel_error}, 32'd0);
    #2 reset = 1'b0;
    tick();
    check("t6_settle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    out_ready = 1'b1;
    drain_expect("t6", 32'h0D0C0B0A, 2'd2);
    check("t6_frame", {31'd0, frame_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
